decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
// - RV32I decode stage of the 5-stage pipeline. Sits between fetch (IF) and execute (EX).
// - Registers the fetched instruction and PC, classifies the opcode, and extracts register
//   indices, funct fields and the sign-extended immediate. Flags illegal encodings.
// - Detects load-use hazards against the instruction it is handing to EX. On a hazard it
//   requests an IF stall and inserts one bubble.
// PARAMETERS
// - PC_RESET  32'h0  value driven on decode_pc while in reset
// PORTS
// - clk                 in   1   clock, rising edge
// - rst                 in   1   asynchronous, active-low reset (0 = reset)
// - clk_en              in   1   fetch_instr/pc valid this cycle (driven by fetch next_clk_en)
// - fetch_instr         in   32  instruction word from fetch
// - pc                  in   32  PC of fetch_instr
// - stall               in   1   downstream stall; hold all decode registers
// - flush               in   1   kill the instruction in decode (taken branch/trap)
// - stall_req           out  1   combinational load-use stall request to fetch
// - decode_pc           out  32  registered PC
// - decode_rs1_addr     out  5   rs1 index; 0 when the format has no rs1 (U/J)
// - decode_rs2_addr     out  5   rs2 index; 0 when the format has no rs2 (I/U/J)
// - decode_rd_addr      out  5   rd index; 0 when the format has no rd (S/B)
// - decode_imm          out  32  sign-extended immediate (I/S/B/U/J), 0 for R-type
// - decode_funct3       out  3   instr[14:12]
// - decode_funct7_b5    out  1   instr[30] (SUB/SRA select)
// - decode_opcode_type  out  11  one-hot: LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP_IMM,OP,FENCE,SYSTEM
// - decode_illegal      out  1   illegal encoding (opcode_type all zero in that case)
// - decode_valid        out  1   outputs hold a real instruction
// - next_clk_en         out  1   decode_valid & ~stall; feeds EX clk_en
// BEHAVIOUR
// - Reset (rst=0, async): every output 0; decode_pc=PC_RESET. stall_req is 0 because decode_valid=0.
// - Latency: 1 cycle. An instruction accepted at edge N is on decode_* after edge N.
// - Register update priority per edge:
//   flush > stall > stall_req > clk_en.
//   - flush: decode_valid<=0; other fields don't care.
//   - stall: hold all registers.
//   - stall_req: decode_valid<=0 (bubble); fetch holds its instruction.
//   - clk_en: capture and decode.
//   - none of the above: decode_valid<=0.
// - Load-use hazard, computed from current register contents:
//   - stall_req = decode_valid & opcode_type==LOAD & decode_rd_addr!=0 & clk_en & ~flush
//     & (rs1(fetch_instr)==rd | rs2(fetch_instr)==rd).
//   - rs1/rs2 here are the format-masked indices.
//   - stall_req lasts exactly 1 cycle unless stall holds the load in place.
//   - Top level ORs stall_req into the fetch stall input.
// - Immediates:
//   - I: {{20{i[31]}},i[31:20]}
//   - S: {{20{i[31]}},i[31:25],i[11:7]}
//   - B: {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
//   - U: {i[31:12],12'b0}
//   - J: {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}
// - Illegal conditions:
//   - instr[1:0]!=2'b11 or unknown opcode.
//   - BRANCH funct3 in {2,3}.
//   - LOAD funct3 in {3,6,7}.
//   - STORE funct3>2.
//   - JALR funct3!=0.
//   - OP funct7 not in {0x00,0x20}, or funct7=0x20 with funct3 not in {0,5}.
//   - OP_IMM shift with bad funct7.
//   - An illegal instruction still sets decode_valid=1; EX handles the trap.
// - Reset asserted mid-stall or mid-bubble: state cleared at once, no pending stall_req.
// STRUCTURE
// - rv32i_pkg: opcode constants, one-hot type index localparams, funct3 constants,
//   OPCODE_TYPE_W=11.
// - Sub-module imm_gen: combinational; takes the instruction and opcode_type, returns a 32-bit imm.
// - Remainder: classify, field mask, legality check, hazard compare, pipeline register.
// TESTING
// - Release reset, then clk_en=1 with 0x00500093 (addi x1,x0,5):
//   valid=1, OP_IMM, rd=1, rs1=0, rs2=0, imm=5.
// - 0xFE208CE3 (beq x1,x2,-8), pc=0x40:
//   BRANCH, rs1=1, rs2=2, rd=0, imm=0xFFFFFFF8, decode_pc=0x40.
// - 0x123452B7 (lui x5,0x12345): LUI, rd=5, rs1=rs2=0, imm=0x12345000.
// - 0x0000A103 (lw x2,0(x1)) then 0x002101B3 (add x3,x2,x2):
//   stall_req=1 for 1 cycle, then a bubble (valid=0), then the add is decoded.
//   Repeat with add x3,x1,x1: no stall_req.
// - 0xFFFFFFFF and 0x0000B0E7: illegal=1, valid=1, opcode_type=0.
// - flush=1 and stall=1 together: valid=0 next edge.
//   Pull rst low mid-stall_req: all outputs 0 immediately, stall_req=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I opcode/funct constants and one-hot instruction-type indices shared by
// the decode stage and its immediate generator.
package rv32i_pkg;

   localparam int OPCODE_TYPE_W = 11;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Bit positions inside decode_opcode_type
   localparam int T_LUI    = 0;
   localparam int T_AUIPC  = 1;
   localparam int T_JAL    = 2;
   localparam int T_JALR   = 3;
   localparam int T_BRANCH = 4;
   localparam int T_LOAD   = 5;
   localparam int T_STORE  = 6;
   localparam int T_OP_IMM = 7;
   localparam int T_OP     = 8;
   localparam int T_FENCE  = 9;
   localparam int T_SYSTEM = 10;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef logic [OPCODE_TYPE_W-1:0] optype_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects the RV32I immediate format from
// the one-hot opcode type; R-type and illegal encodings yield zero.
module imm_gen
   import rv32i_pkg::*;
(
   input  logic [31:7] i_instr,
   input  optype_t     i_type,
   output logic [31:0] o_imm
);

   always_comb begin
      o_imm = '0;
      case (1'b1)
         i_type[T_LUI], i_type[T_AUIPC]:
            o_imm = {i_instr[31:12], 12'b0};
         i_type[T_JAL]:
            o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};
         i_type[T_BRANCH]:
            o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
         i_type[T_STORE]:
            o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         i_type[T_JALR], i_type[T_LOAD], i_type[T_OP_IMM],
         i_type[T_FENCE], i_type[T_SYSTEM]:
            o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
         i_type[T_OP]:
            o_imm = '0;
         default:
            o_imm = '0;
      endcase
   end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: registers the fetched instruction, classifies it, extracts
// fields/immediate, flags illegal encodings and requests a bubble on load-use.
module decode
   import rv32i_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic [31:0] fetch_instr,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        flush,
   output logic        stall_req,
   output logic [31:0] decode_pc,
   output logic [4:0]  decode_rs1_addr,
   output logic [4:0]  decode_rs2_addr,
   output logic [4:0]  decode_rd_addr,
   output logic [31:0] decode_imm,
   output logic [2:0]  decode_funct3,
   output logic        decode_funct7_b5,
   output optype_t     decode_opcode_type,
   output logic        decode_illegal,
   output logic        decode_valid,
   output logic        next_clk_en
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   optype_t     w_type;
   logic        w_legal;
   logic        w_has_rs1, w_has_rs2, w_has_rd;
   logic [4:0]  w_rs1, w_rs2, w_rd;
   logic [31:0] w_imm;
   logic        w_hit;

   logic [31:0] r_pc;
   logic [4:0]  r_rs1, r_rs2, r_rd;
   logic [31:0] r_imm;
   logic [2:0]  r_f3;
   logic        r_f7b5;
   optype_t     r_type;
   logic        r_illegal;
   logic        r_valid;

   assign w_opc = fetch_instr[6:0];
   assign w_f3  = fetch_instr[14:12];
   assign w_f7  = fetch_instr[31:25];

   always_comb begin
      w_type  = '0;
      w_legal = 1'b0;
      case (w_opc)
         OPC_LUI:    begin w_type[T_LUI]    = 1'b1; w_legal = 1'b1; end
         OPC_AUIPC:  begin w_type[T_AUIPC]  = 1'b1; w_legal = 1'b1; end
         OPC_JAL:    begin w_type[T_JAL]    = 1'b1; w_legal = 1'b1; end
         OPC_JALR:   begin w_type[T_JALR]   = 1'b1; w_legal = (w_f3 == F3_ADD); end
         OPC_BRANCH: begin
            w_type[T_BRANCH] = 1'b1;
            w_legal = (w_f3 != 3'd2) && (w_f3 != 3'd3);
         end
         OPC_LOAD:   begin
            w_type[T_LOAD] = 1'b1;
            w_legal = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
         end
         OPC_STORE:  begin w_type[T_STORE]  = 1'b1; w_legal = (w_f3 <= 3'd2); end
         OPC_OP_IMM: begin
            w_type[T_OP_IMM] = 1'b1;
            if (w_f3 == F3_SLL)     w_legal = (w_f7 == F7_BASE);
            else if (w_f3 == F3_SR) w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
            else                    w_legal = 1'b1;
         end
         OPC_OP:     begin
            w_type[T_OP] = 1'b1;
            w_legal = (w_f7 == F7_BASE) ||
                      ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)));
         end
         OPC_FENCE:  begin w_type[T_FENCE]  = 1'b1; w_legal = 1'b1; end
         OPC_SYSTEM: begin w_type[T_SYSTEM] = 1'b1; w_legal = 1'b1; end
         default:    begin w_type = '0;             w_legal = 1'b0; end
      endcase
      // EX keys its trap off decode_illegal, so an illegal word carries no type
      if (!w_legal) w_type = '0;
   end

   assign w_has_rs1 = ~(w_type[T_LUI] | w_type[T_AUIPC] | w_type[T_JAL]);
   assign w_has_rs2 = w_type[T_BRANCH] | w_type[T_STORE] | w_type[T_OP];
   assign w_has_rd  = ~(w_type[T_BRANCH] | w_type[T_STORE]);
   assign w_rs1 = w_has_rs1 ? fetch_instr[19:15] : 5'd0;
   assign w_rs2 = w_has_rs2 ? fetch_instr[24:20] : 5'd0;
   assign w_rd  = w_has_rd  ? fetch_instr[11:7]  : 5'd0;

   imm_gen u_imm_gen (
      .i_instr (fetch_instr[31:7]),
      .i_type  (w_type),
      .o_imm   (w_imm)
   );

   // Masked indices keep U/J immediates from aliasing onto the load's rd
   assign w_hit     = (w_rs1 == r_rd) || (w_rs2 == r_rd);
   assign stall_req = r_valid & r_type[T_LOAD] & (r_rd != 5'd0) & clk_en & ~flush & w_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc      <= PC_RESET;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_imm     <= '0;
         r_f3      <= '0;
         r_f7b5    <= 1'b0;
         r_type    <= '0;
         r_illegal <= 1'b0;
         r_valid   <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (!stall) begin
         if (stall_req) begin
            r_valid <= 1'b0;
         end else if (clk_en) begin
            r_pc      <= pc;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_imm     <= w_imm;
            r_f3      <= w_f3;
            r_f7b5    <= fetch_instr[30];
            r_type    <= w_type;
            r_illegal <= ~w_legal;
            r_valid   <= 1'b1;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign decode_pc          = r_pc;
   assign decode_rs1_addr    = r_rs1;
   assign decode_rs2_addr    = r_rs2;
   assign decode_rd_addr     = r_rd;
   assign decode_imm         = r_imm;
   assign decode_funct3      = r_f3;
   assign decode_funct7_b5   = r_f7b5;
   assign decode_opcode_type = r_type;
   assign decode_illegal     = r_illegal;
   assign decode_valid       = r_valid;
   assign next_clk_en        = r_valid & ~stall;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the RV32I decode stage: a table of single instructions
// plus hand-written load-use, stall/flush and mid-hazard reset sequences.
module tb_decode;
   import rv32i_pkg::*;

   logic        clk, rst, clk_en, stall, flush;
   logic [31:0] fetch_instr, pc;
   logic        stall_req, decode_funct7_b5, decode_illegal, decode_valid, next_clk_en;
   logic [31:0] decode_pc, decode_imm;
   logic [4:0]  decode_rs1_addr, decode_rs2_addr, decode_rd_addr;
   logic [2:0]  decode_funct3;
   optype_t     decode_opcode_type;

   int n_chk = 0;
   int n_err = 0;

   decode #(.PC_RESET(32'h0)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .fetch_instr(fetch_instr), .pc(pc),
      .stall(stall), .flush(flush), .stall_req(stall_req), .decode_pc(decode_pc),
      .decode_rs1_addr(decode_rs1_addr), .decode_rs2_addr(decode_rs2_addr),
      .decode_rd_addr(decode_rd_addr), .decode_imm(decode_imm),
      .decode_funct3(decode_funct3), .decode_funct7_b5(decode_funct7_b5),
      .decode_opcode_type(decode_opcode_type), .decode_illegal(decode_illegal),
      .decode_valid(decode_valid), .next_clk_en(next_clk_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      int          tix;    // expected type bit index, -1 for illegal
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
   } vec_t;

   localparam logic [31:0] LW_X2   = 32'h0000A103;
   localparam logic [31:0] ADD_X22 = 32'h002101B3;
   localparam logic [31:0] ADD_X11 = 32'h001081B3;
   localparam logic [31:0] ADDI    = 32'h00500093;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] p);
      @(negedge clk);
      fetch_instr = ins;
      pc          = p;
      clk_en      = 1'b1;
   endtask

   function automatic logic [31:0] onehot(input int tix);
      logic [31:0] v;
      v = '0;
      if (tix >= 0) v[tix] = 1'b1;
      return v;
   endfunction

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{32'h00500093, 32'h100, T_OP_IMM, 5'd1, 5'd0, 5'd0, 32'h5};
      vecs[1]  = '{32'hFE208CE3, 32'h040, T_BRANCH, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8};
      vecs[2]  = '{32'h123452B7, 32'h108, T_LUI,    5'd5, 5'd0, 5'd0, 32'h12345000};
      vecs[3]  = '{32'h0020A423, 32'h10C, T_STORE,  5'd0, 5'd1, 5'd2, 32'h8};
      vecs[4]  = '{32'h010000EF, 32'h110, T_JAL,    5'd1, 5'd0, 5'd0, 32'h10};
      vecs[5]  = '{32'h402081B3, 32'h114, T_OP,     5'd3, 5'd1, 5'd2, 32'h0};
      vecs[6]  = '{32'h4010D093, 32'h118, T_OP_IMM, 5'd1, 5'd1, 5'd0, 32'h401};
      vecs[7]  = '{32'h00001117, 32'h11C, T_AUIPC,  5'd2, 5'd0, 5'd0, 32'h1000};
      vecs[8]  = '{32'h000100E7, 32'h120, T_JALR,   5'd1, 5'd2, 5'd0, 32'h0};
      vecs[9]  = '{32'h00000073, 32'h124, T_SYSTEM, 5'd0, 5'd0, 5'd0, 32'h0};
      vecs[10] = '{32'h0000000F, 32'h128, T_FENCE,  5'd0, 5'd0, 5'd0, 32'h0};
      vecs[11] = '{32'hFFFFFFFF, 32'h12C, -1, 5'd0, 5'd0, 5'd0, 32'h0};
      vecs[12] = '{32'h0000B0E7, 32'h130, -1, 5'd0, 5'd0, 5'd0, 32'h0};
      vecs[13] = '{32'h402091B3, 32'h134, -1, 5'd0, 5'd0, 5'd0, 32'h0};
      vecs[14] = '{32'h40109093, 32'h138, -1, 5'd0, 5'd0, 5'd0, 32'h0};
      vecs[15] = '{32'h0000B103, 32'h13C, -1, 5'd0, 5'd0, 5'd0, 32'h0};

      rst = 1'b0; clk_en = 1'b0; stall = 1'b0; flush = 1'b0;
      fetch_instr = '0; pc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(decode_valid), 32'h0);
      chk("rst_pc", decode_pc, 32'h0);
      chk("rst_type", 32'(decode_opcode_type), 32'h0);
      chk("rst_imm", decode_imm, 32'h0);
      chk("rst_stall_req", 32'(stall_req), 32'h0);
      chk("rst_next_clk_en", 32'(next_clk_en), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].instr, vecs[i].pc);
         @(posedge clk); #1;
         chk($sformatf("v%0d_valid", i), 32'(decode_valid), 32'h1);
         chk($sformatf("v%0d_type", i), 32'(decode_opcode_type), onehot(vecs[i].tix));
         chk($sformatf("v%0d_illegal", i), 32'(decode_illegal), 32'(vecs[i].tix < 0));
         chk($sformatf("v%0d_pc", i), decode_pc, vecs[i].pc);
         if (vecs[i].tix >= 0) begin
            chk($sformatf("v%0d_rd", i), 32'(decode_rd_addr), 32'(vecs[i].rd));
            chk($sformatf("v%0d_rs1", i), 32'(decode_rs1_addr), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 32'(decode_rs2_addr), 32'(vecs[i].rs2));
            chk($sformatf("v%0d_imm", i), decode_imm, vecs[i].imm);
         end
      end
      @(negedge clk); clk_en = 1'b0;
      @(posedge clk); #1;
      chk("idle_valid", 32'(decode_valid), 32'h0);

      // load-use on both sources: one bubble, then the add
      drive(LW_X2, 32'h200);
      @(posedge clk); #1;
      chk("lu_load_type", 32'(decode_opcode_type), onehot(T_LOAD));
      chk("lu_load_rd", 32'(decode_rd_addr), 32'd2);
      drive(ADD_X22, 32'h204); #1;
      chk("lu_stall_req", 32'(stall_req), 32'h1);
      @(posedge clk); #1;
      chk("lu_bubble_valid", 32'(decode_valid), 32'h0);
      chk("lu_stall_req_drop", 32'(stall_req), 32'h0);
      @(posedge clk); #1;
      chk("lu_add_valid", 32'(decode_valid), 32'h1);
      chk("lu_add_pc", decode_pc, 32'h204);
      chk("lu_add_rs1", 32'(decode_rs1_addr), 32'd2);
      chk("lu_add_rd", 32'(decode_rd_addr), 32'd3);

      // no dependency: no stall
      drive(LW_X2, 32'h300);
      @(posedge clk);
      drive(ADD_X11, 32'h304); #1;
      chk("nodep_stall_req", 32'(stall_req), 32'h0);
      @(posedge clk); #1;
      chk("nodep_valid", 32'(decode_valid), 32'h1);
      chk("nodep_pc", decode_pc, 32'h304);

      // downstream stall holds the load, keeping stall_req up
      drive(LW_X2, 32'h400);
      @(posedge clk);
      drive(ADD_X22, 32'h404); stall = 1'b1; #1;
      chk("hold_stall_req", 32'(stall_req), 32'h1);
      chk("hold_next_clk_en", 32'(next_clk_en), 32'h0);
      @(posedge clk); #1;
      chk("hold_valid", 32'(decode_valid), 32'h1);
      chk("hold_pc", decode_pc, 32'h400);
      chk("hold_stall_req2", 32'(stall_req), 32'h1);
      @(negedge clk); stall = 1'b0;
      @(posedge clk); #1;
      chk("hold_bubble", 32'(decode_valid), 32'h0);
      @(posedge clk); #1;
      chk("hold_add_pc", decode_pc, 32'h404);
      chk("hold_add_valid", 32'(decode_valid), 32'h1);

      // flush beats stall
      drive(ADDI, 32'h500); flush = 1'b1; stall = 1'b1;
      @(posedge clk); #1;
      chk("flush_valid", 32'(decode_valid), 32'h0);
      @(negedge clk); flush = 1'b0; stall = 1'b0;
      @(posedge clk); #1;
      chk("after_flush_pc", decode_pc, 32'h500);

      // flush masks a pending load-use request
      drive(LW_X2, 32'h580);
      @(posedge clk);
      drive(ADD_X22, 32'h584); flush = 1'b1; #1;
      chk("flush_stall_req", 32'(stall_req), 32'h0);
      @(negedge clk); flush = 1'b0;

      // async reset while stall_req is up
      drive(LW_X2, 32'h600);
      @(posedge clk);
      drive(ADD_X22, 32'h604); #1;
      chk("mid_stall_req", 32'(stall_req), 32'h1);
      #1 rst = 1'b0; #1;
      chk("arst_stall_req", 32'(stall_req), 32'h0);
      chk("arst_valid", 32'(decode_valid), 32'h0);
      chk("arst_pc", decode_pc, 32'h0);
      chk("arst_rd", 32'(decode_rd_addr), 32'h0);
      chk("arst_type", 32'(decode_opcode_type), 32'h0);
      @(posedge clk); #1;
      chk("arst_hold_valid", 32'(decode_valid), 32'h0);
      @(negedge clk); rst = 1'b1; clk_en = 1'b0;
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
